// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the IF/D memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;

   localparam int unsigned DEF_MEM_LATENCY  = 2;
   localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// Grant decision between IF and D ports, with the IF starvation counter.
module mem_arb_sel
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   if_req,
   input  logic   d_req,
   input  logic   grant,
   output owner_t owner
);

   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [SW-1:0] starve;
   logic          starved;

   assign starved = (starve == SW'(STARVE_LIMIT));

   // D wins unless IF has waited through STARVE_LIMIT D grants.
   always_comb begin
      owner = OWN_IF;
      if (d_req && !(if_req && starved))
         owner = OWN_D;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve <= '0;
      end else if (grant) begin
         if (owner == OWN_IF)
            starve <= '0;
         else if (if_req && !starved)
            starve <= starve + 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a single-port memory between the CPU instruction-fetch and data ports.
module memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LATENCY  = DEF_MEM_LATENCY,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_dout,
   output logic        busy
);

   localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   state_t        state, state_nxt;
   owner_t        owner, sel_owner;
   logic [CW-1:0] cnt;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic          lat_we;
   logic          grant;
   logic          last_cycle;

   assign grant      = (state == ST_IDLE) && (if_req || d_req);
   assign last_cycle = (cnt == '0);

   mem_arb_sel #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_sel (
      .clk   (clk),
      .reset (reset),
      .if_req(if_req),
      .d_req (d_req),
      .grant (grant),
      .owner (sel_owner)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if_ready  = 1'b0;
      d_ready   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant)
               state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            busy      = 1'b1;
            mem_addr  = lat_addr;
            mem_din   = lat_wdata;
            mem_read  = !lat_we;
            // A single write strobe, placed where the data is guaranteed stable.
            mem_write = lat_we && last_cycle;
            if (last_cycle)
               state_nxt = ST_RESP;
         end
         ST_RESP: begin
            busy      = 1'b1;
            if_ready  = (owner == OWN_IF);
            d_ready   = (owner == OWN_D);
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner     <= OWN_IF;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else if (grant) begin
         owner <= sel_owner;
         cnt   <= CW'(MEM_LATENCY - 1);
         if (sel_owner == OWN_D) begin
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_we    <= d_we;
         end else begin
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
         end
      end else if (state == ST_ACCESS) begin
         if (!last_cycle) begin
            cnt <= cnt - 1'b1;
         end else if (lat_we) begin
            d_rdata <= '0;
         end else if (owner == OWN_D) begin
            d_rdata <= mem_dout;
         end else begin
            if_rdata <= mem_dout;
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: per-port expected-response queues checked by a monitor.
module tb_memory_arbiter;

   typedef struct packed {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_dout;
   logic        busy;

   logic        l1_if_req;
   logic [31:0] l1_if_addr;
   logic        l1_if_ready;
   logic [31:0] l1_if_rdata;
   logic        l1_d_req;
   logic        l1_d_we;
   logic [31:0] l1_d_addr;
   logic [31:0] l1_d_wdata;
   logic        l1_d_ready;
   logic [31:0] l1_d_rdata;
   logic [31:0] l1_mem_addr;
   logic [31:0] l1_mem_din;
   logic        l1_mem_read;
   logic        l1_mem_write;
   logic [31:0] l1_mem_dout;
   logic        l1_busy;

   logic [31:0] mem [0:255];
   bit          mem_init;
   int          cyc;
   int          wr_cnt, wr_last_cyc;
   int          rd_cnt, rd_last_cyc;
   logic [31:0] rd_last_addr;
   int          tests, fails;
   exp_t        sb_d[$];
   exp_t        sb_if[$];

   memory_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
      .mem_dout(mem_dout), .busy(busy)
   );

   memory_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
      .clk(clk), .reset(reset),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ready(l1_if_ready), .if_rdata(l1_if_rdata),
      .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
      .d_ready(l1_d_ready), .d_rdata(l1_d_rdata),
      .mem_addr(l1_mem_addr), .mem_din(l1_mem_din), .mem_read(l1_mem_read),
      .mem_write(l1_mem_write), .mem_dout(l1_mem_dout), .busy(l1_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_dout    = mem[mem_addr[9:2]];
   assign l1_mem_dout = ~l1_mem_addr;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[4]   <= 32'hDEADBEEF;
         mem[32]  <= 32'h11111111;
         mem_init <= 1'b1;
      end else if (mem_write) begin
         mem[mem_addr[9:2]] <= mem_din;
      end
      if (mem_write) begin
         wr_cnt      <= wr_cnt + 1;
         wr_last_cyc <= cyc;
      end
      if (mem_read) begin
         rd_cnt       <= rd_cnt + 1;
         rd_last_cyc  <= cyc;
         rd_last_addr <= mem_addr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (if_ready || d_ready)
         chk("single_ready", {31'b0, if_ready & d_ready}, 32'h0);
      if (d_ready) begin
         if (sb_d.size() == 0) begin
            tests++; fails++;
            $display("FAIL d_unexpected_ready: got ready expected none (cycle %0d)", cyc);
         end else begin
            e = sb_d.pop_front();
            chk("d_rdata", d_rdata, e.data);
            chk("d_ready_cycle", cyc, e.cyc);
         end
      end
      if (if_ready) begin
         if (sb_if.size() == 0) begin
            tests++; fails++;
            $display("FAIL if_unexpected_ready: got ready expected none (cycle %0d)", cyc);
         end else begin
            e = sb_if.pop_front();
            chk("if_rdata", if_rdata, e.data);
            chk("if_ready_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic wait_ready(input bit is_d);
      int n;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (is_d ? d_ready : if_ready) break;
      end
      if (n == 40) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", is_d ? "d" : "if");
      end
   endtask

   task automatic if_access(input logic [31:0] a, input logic [31:0] ed, input int off,
                            output int k);
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = a;
      k = cyc;
      sb_if.push_back('{data: ed, cyc: k + off});
      wait_ready(1'b0);
      if_req = 1'b0;
   endtask

   task automatic d_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] ed, input int off, output int k);
      @(negedge clk);
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      k = cyc;
      sb_d.push_back('{data: ed, cyc: k + off});
      wait_ready(1'b1);
      d_req = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      {31'b0, busy},      32'h0);
      chk({tag, "_if_ready"},  {31'b0, if_ready},  32'h0);
      chk({tag, "_d_ready"},   {31'b0, d_ready},   32'h0);
      chk({tag, "_mem_read"},  {31'b0, mem_read},  32'h0);
      chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'h0);
      chk({tag, "_mem_addr"},  mem_addr, 32'h0);
      chk({tag, "_mem_din"},   mem_din,  32'h0);
      chk({tag, "_if_rdata"},  if_rdata, 32'h0);
      chk({tag, "_d_rdata"},   d_rdata,  32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, kd, ki, wr0, rd0, got, n;
      cyc = 0; wr_cnt = 0; rd_cnt = 0; wr_last_cyc = -1; rd_last_cyc = -1; rd_last_addr = '0;
      tests = 0; fails = 0;
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      l1_if_req = 1'b0; l1_if_addr = '0;
      l1_d_req = 1'b0; l1_d_we = 1'b0; l1_d_addr = '0; l1_d_wdata = '0;

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      chk("reset_l1_busy", {31'b0, l1_busy}, 32'h0);
      reset = 1'b1;

      // IF read of 0x10
      rd0 = rd_cnt; wr0 = wr_cnt;
      if_access(32'h10, 32'hDEADBEEF, 3, k);
      chk("ifrd_read_cycles", rd_cnt - rd0, 2);
      chk("ifrd_last_read_cycle", rd_last_cyc, k + 2);
      chk("ifrd_addr", rd_last_addr, 32'h10);
      chk("ifrd_no_write", wr_cnt - wr0, 0);

      // D write 0x12345678 to 0x40, then read it back
      wr0 = wr_cnt;
      d_access(1'b1, 32'h40, 32'h12345678, 32'h0, 3, k);
      chk("dwr_write_pulses", wr_cnt - wr0, 1);
      chk("dwr_write_cycle", wr_last_cyc, k + 2);
      chk("dwr_mem", mem[16], 32'h12345678);
      d_access(1'b0, 32'h40, 32'h0, 32'h12345678, 3, k);
      // a write following a read must clear d_rdata
      d_access(1'b1, 32'h44, 32'h0BADF00D, 32'h0, 3, k);
      chk("dwr2_mem", mem[17], 32'h0BADF00D);

      // simultaneous requests: D first, IF sampled at the following IDLE edge
      fork
         d_access(1'b0, 32'h40, 32'h0, 32'h12345678, 3, kd);
         if_access(32'h10, 32'hDEADBEEF, 7, ki);
      join
      chk("simul_d_rdata_held", d_rdata, 32'h12345678);

      // starvation: both held; D x4, IF, D
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      if_req = 1'b1; if_addr = 32'h10;
      k = cyc;
      sb_d.push_back('{data: 32'h12345678, cyc: k + 3});
      sb_d.push_back('{data: 32'h12345678, cyc: k + 7});
      sb_d.push_back('{data: 32'h12345678, cyc: k + 11});
      sb_d.push_back('{data: 32'h12345678, cyc: k + 15});
      sb_if.push_back('{data: 32'hDEADBEEF, cyc: k + 19});
      sb_d.push_back('{data: 32'h12345678, cyc: k + 23});
      got = 0;
      for (n = 0; n < 80 && got < 6; n++) begin
         @(negedge clk);
         if (d_ready || if_ready) got++;
      end
      chk("starve_grants_seen", got, 6);
      d_req = 1'b0; if_req = 1'b0;

      // reset during a D write to 0x80
      wr0 = wr_cnt;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("rst_busy_before", {31'b0, busy}, 32'h1);
      reset = 1'b0;
      #1;
      chk_all_zero("rstmid");
      @(negedge clk);
      reset = 1'b1;
      k = cyc;
      sb_d.push_back('{data: 32'h0, cyc: k + 3});
      @(negedge clk);
      chk("rstmid_no_write", wr_cnt - wr0, 0);
      chk("rstmid_mem_kept", mem[32], 32'h11111111);
      wait_ready(1'b1);
      d_req = 1'b0;
      chk("rstmid_write_once", wr_cnt - wr0, 1);
      chk("rstmid_mem_written", mem[32], 32'hCAFEF00D);

      // MEM_LATENCY = 1 instance
      @(negedge clk);
      l1_if_req = 1'b1; l1_if_addr = 32'h24;
      @(negedge clk);
      chk("l1_read_c1", {31'b0, l1_mem_read}, 32'h1);
      chk("l1_addr_c1", l1_mem_addr, 32'h24);
      chk("l1_ready_c1", {31'b0, l1_if_ready}, 32'h0);
      @(negedge clk);
      chk("l1_read_c2", {31'b0, l1_mem_read}, 32'h0);
      chk("l1_ready_c2", {31'b0, l1_if_ready}, 32'h1);
      chk("l1_rdata", l1_if_rdata, 32'hFFFFFFDB);
      l1_if_req = 1'b0;

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb_d.size() + sb_if.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
